ov7670_stream_gen: RTL and testbench

- Bench/bring-up transmitter that emulates the OV7670 parallel video output in YUV422 byte order.
- Drives xclk-domain signals pclk, vsync, href and d[7:0] into the frame-capture/decimation receiver.
- Lets capture, decimation and SPI readout be exercised with known frames and no camera attached.
- Generates programmable test patterns with OV7670-style frame and line blanking.

---
 rtl/ov7670_stream_gen_if.sv | 35 +++
 rtl/ov7670_stream_gen.sv | 188 ++++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_stream_gen_if.sv
// Control and video bundle of the OV7670-style stream generator.
//   master : generator side (drives the camera-like video outputs)
//   slave  : consumer / stimulus side (drives start and pattern controls)
// Signals:
//   start        one-clk frame request
//   continuous   chain the next frame at end of frame
//   pattern_sel  0 col ramp, 1 row ramp, 2 constant, 3 checkerboard
//   y_level      Y value for the constant pattern
//   pclk         pixel clock, clk/2
//   vsync, href  frame / line valid, active-high
//   d            pixel byte (Y, chroma alternating)
//   busy         frame in progress
//   frame_done   one-clk end-of-frame pulse
interface ov7670_stream_gen_if;
  logic       start;
  logic       continuous;
  logic [1:0] pattern_sel;
  logic [7:0] y_level;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] d;
  logic       busy;
  logic       frame_done;

  modport master (
    input  start, continuous, pattern_sel, y_level,
    output pclk, vsync, href, d, busy, frame_done
  );

  modport slave (
    output start, continuous, pattern_sel, y_level,
    input  pclk, vsync, href, d, busy, frame_done
  );
endinterface

// File: rtl/ov7670_stream_gen.sv
// OV7670 parallel-output emulator (YUV422 byte order) for bring-up of the
// capture path without a camera. Produces vsync/href/d with frame and line
// blanking and one of four test patterns.
// Ports:
//   clk    system clock (pclk is derived as clk/2)
//   reset  asynchronous, active-low
//   vid    ov7670_stream_gen_if.master (start/continuous/pattern controls in,
//          pclk/vsync/href/d/busy/frame_done out)
// Build option:
//   STREAM_FRAME_TAG_EN  when defined, an 8-bit frame counter replaces the
//                        Y byte of pixel (row 0, col 0) of every frame.
module ov7670_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  ov7670_stream_gen_if.master    vid
);

  localparam int LINE = 2*H_ACTIVE + H_BLANK;
  localparam int BW   = $clog2(LINE);
  localparam int LW   = $clog2(V_ACTIVE + VSYNC_LINES + V_BACK + V_FRONT);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT, DONE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [LW-1:0]   line_q, line_d, last_line;
  logic            pclk_q, busy_q, busy_d;
  logic            vsync_q, href_q, done_q;
  logic [7:0]      d_q;
  logic [1:0]      pat_q;
  logic [7:0]      ylev_q;
  logic            tick, eol, frame_begin;
  logic            vsync_n, href_n;
  logic [7:0]      y_n, d_n;
  logic [31:0]     bx, rx;
`ifdef STREAM_FRAME_TAG_EN
  logic [7:0]      tag_q;
`endif

  // Byte-period strobe: true on the clk edge where pclk falls, so all video
  // outputs change there and are stable at the following pclk rise.
  assign tick = pclk_q;
  assign eol  = (byte_q == BW'(LINE-1));

  always_comb begin
    last_line = '0;
    case (state_q)
      VSYNC:   last_line = LW'(VSYNC_LINES-1);
      VBACK:   last_line = LW'(V_BACK-1);
      ACTIVE:  last_line = LW'(V_ACTIVE-1);
      VFRONT:  last_line = LW'(V_FRONT-1);
      default: last_line = '0;
    endcase
  end

  // Next state: counters describe the byte being driven; they advance only
  // on byte ticks. busy is the only thing that can change between ticks.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    line_d  = line_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (!busy_q) begin
          if (vid.start) busy_d = 1'b1;
        end else if (tick) begin
          state_d = VSYNC;
          byte_d  = '0;
          line_d  = '0;
        end
      end
      VSYNC, VBACK, ACTIVE, VFRONT: begin
        if (tick) begin
          if (eol) begin
            byte_d = '0;
            if (line_q == last_line) begin
              line_d = '0;
              case (state_q)
                VSYNC:   state_d = VBACK;
                VBACK:   state_d = ACTIVE;
                ACTIVE:  state_d = VFRONT;
                default: state_d = DONE;
              endcase
            end else begin
              line_d = line_q + LW'(1);
            end
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end
      end
      DONE: begin
        // start is never sampled here (busy is still high); only
        // continuous decides whether another frame follows.
        if (tick) begin
          byte_d = '0;
          line_d = '0;
          if (vid.continuous) begin
            state_d = VSYNC;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output values for the byte about to be driven (position given by *_d).
  always_comb begin
    frame_begin = tick && (state_d == VSYNC) && (state_q != VSYNC);
    vsync_n     = (state_d == VSYNC);
    href_n      = (state_d == ACTIVE) && ({1'b0, byte_d} < (BW+1)'(2*H_ACTIVE));
    bx          = 32'(byte_d);
    rx          = 32'(line_d);
    // col = byte>>1, so col[9:2] = byte>>3 and col[6] = byte[7].
    case (pat_q)
      2'd0:    y_n = 8'(bx >> 3);
      2'd1:    y_n = 8'(rx >> 1);
      2'd2:    y_n = ylev_q;
      default: y_n = (bx[7] ^ rx[6]) ? 8'hFF : 8'h00;
    endcase
`ifdef STREAM_FRAME_TAG_EN
    if (line_d == '0 && byte_d == '0) y_n = tag_q;
`endif
    d_n = href_n ? (byte_d[0] ? 8'h80 : y_n) : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      line_q  <= '0;
      pclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      d_q     <= 8'h00;
      done_q  <= 1'b0;
      pat_q   <= 2'd0;
      ylev_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      pclk_q  <= ~pclk_q;
      busy_q  <= busy_d;
      // DONE is entered on a tick and left on the next, so this is one clk.
      done_q  <= tick && (state_d == DONE);
      if (tick) begin
        vsync_q <= vsync_n;
        href_q  <= href_n;
        d_q     <= d_n;
      end
      if (frame_begin) begin
        pat_q  <= vid.pattern_sel;
        ylev_q <= vid.y_level;
      end
    end
  end

`ifdef STREAM_FRAME_TAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     tag_q <= 8'h00;
    else if (tick && state_d == DONE) tag_q <= tag_q + 8'd1;
  end
`endif

  assign vid.pclk       = pclk_q;
  assign vid.vsync      = vsync_q;
  assign vid.href       = href_q;
  assign vid.d          = d_q;
  assign vid.busy       = busy_q;
  assign vid.frame_done = done_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
module tb_ov7670_stream_gen;

  // Small instance: timing and sequencing; medium instance: pattern content.
  localparam int S_HA = 4, S_VA = 2, S_HB = 3, S_VS = 1, S_VB = 1, S_VF = 1;
  localparam int M_HA = 66, M_VA = 66, M_HB = 2, M_VS = 1, M_VB = 1, M_VF = 1;

  logic clk = 1'b0;
  logic rst_s, rst_m;
  always #5 clk = ~clk;

  ov7670_stream_gen_if s_if();
  ov7670_stream_gen_if m_if();

  ov7670_stream_gen #(.H_ACTIVE(S_HA), .V_ACTIVE(S_VA), .H_BLANK(S_HB),
    .VSYNC_LINES(S_VS), .V_BACK(S_VB), .V_FRONT(S_VF))
    u_s (.clk(clk), .reset(rst_s), .vid(s_if.master));

  ov7670_stream_gen #(.H_ACTIVE(M_HA), .V_ACTIVE(M_VA), .H_BLANK(M_HB),
    .VSYNC_LINES(M_VS), .V_BACK(M_VB), .V_FRONT(M_VF))
    u_m (.clk(clk), .reset(rst_m), .vid(m_if.master));

  int n_chk = 0, n_fail = 0;
  logic [7:0] s_q[$], m_q[$];
  logic [7:0] s_tag = 8'h00, m_tag = 8'h00;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_y(logic [1:0] pat, logic [7:0] yl, int row, int col);
    logic [15:0] c, r;
    c = 16'(col);
    r = 16'(row);
    case (pat)
      2'd0:    return c[9:2];
      2'd1:    return r[8:1];
      2'd2:    return yl;
      default: return (c[6] ^ r[6]) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Push all href-high bytes of one frame into the scoreboard.
  task automatic push_frame(input bit med, input logic [1:0] pat, input logic [7:0] yl);
    int ha, va;
    logic [7:0] v, tag;
    ha  = med ? M_HA : S_HA;
    va  = med ? M_VA : S_VA;
    tag = med ? m_tag : s_tag;
    for (int r = 0; r < va; r++)
      for (int b = 0; b < 2*ha; b++) begin
        v = b[0] ? 8'h80 : exp_y(pat, yl, r, b/2);
`ifdef STREAM_FRAME_TAG_EN
        if (r == 0 && b == 0) v = tag;
`endif
        if (med) m_q.push_back(v); else s_q.push_back(v);
      end
    if (med) m_tag = m_tag + 8'd1; else s_tag = s_tag + 8'd1;
  endtask

  // ---------------- small-instance monitor ----------------
  int s_vs, s_hr, s_hrise, s_bk, s_done, s_vsrise, s_run, s_clk, s_span;
  int s_gap, s_gap_clk, s_busy_low;
  bit s_vs_prev, s_hr_prev, s_gap_armed;

  task automatic clr_s();
    s_vs = 0; s_hr = 0; s_hrise = 0; s_bk = 0; s_done = 0; s_vsrise = 0;
    s_span = -1; s_gap = -1; s_gap_armed = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_s) begin
      s_vs_prev = 0; s_hr_prev = 0; s_run = 0;
    end else begin
      s_clk++; s_gap_clk++;
      if (s_if.vsync && !s_vs_prev) begin
        s_clk = 0; s_vsrise++;
        if (s_gap_armed) begin s_gap = s_gap_clk; s_gap_armed = 0; end
      end
      s_vs_prev = s_if.vsync;
      if (s_if.frame_done) begin
        s_done++; s_span = s_clk; s_gap_armed = 1; s_gap_clk = 0;
      end
      if (!s_if.busy) s_busy_low++;
      if (s_if.pclk) begin
        if (s_if.vsync) s_vs++;
        if (s_if.href) begin
          if (!s_hr_prev) s_hrise++;
          s_hr++; s_run++;
          if (s_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL s_extra_byte: got 0x%0h with no byte expected at %0t", s_if.d, $time);
          end else chk("s_byte", s_if.d, s_q.pop_front());
        end else begin
          if (s_hr_prev) begin chk("s_href_len", s_run, 2*S_HA); s_run = 0; end
          chk("s_d_blank", s_if.d, 0);
          if (!s_if.vsync && s_vs > 0 && s_hrise == 0) s_bk++;
        end
        s_hr_prev = s_if.href;
      end
    end
  end

  // ---------------- medium-instance monitor ----------------
  int m_done;
  always @(negedge clk) begin
    if (rst_m) begin
      if (m_if.frame_done) m_done++;
      if (m_if.pclk) begin
        if (m_if.href) begin
          if (m_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL m_extra_byte: got 0x%0h with no byte expected at %0t", m_if.d, $time);
          end else chk("m_byte", m_if.d, m_q.pop_front());
        end else chk("m_d_blank", m_if.d, 0);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start(input bit med);
    @(negedge clk);
    if (med) m_if.start = 1'b1; else s_if.start = 1'b1;
    @(negedge clk);
    if (med) m_if.start = 1'b0; else s_if.start = 1'b0;
    chk(med ? "m_busy_rise" : "s_busy_rise", med ? m_if.busy : s_if.busy, 1);
  endtask

  task automatic wait_done(input bit med, input int budget, output bit ok);
    int n;
    ok = 0; n = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (med ? m_if.frame_done : s_if.frame_done) ok = 1;
    end
    chk(med ? "m_frame_done_timeout" : "s_frame_done_timeout", ok, 1);
  endtask

  typedef struct {
    logic [1:0] pat;
    logic [7:0] yl;
    int exp_vs;     // vsync-high byte periods
    int exp_rise;   // href pulses
    int exp_hr;     // href-high bytes
    int exp_bk;     // bytes from vsync fall to first href
    int exp_span;   // clks from vsync rise to frame_done
  } vec_t;

  task automatic run_small();
    vec_t vt[6];
    bit ok;
    int n;
    vt[0] = '{2'd2, 8'h5A, 11, 2, 16, 11, 110};
    vt[1] = '{2'd0, 8'h00, 11, 2, 16, 11, 110};
    vt[2] = '{2'd1, 8'h33, 11, 2, 16, 11, 110};
    vt[3] = '{2'd3, 8'h11, 11, 2, 16, 11, 110};
    vt[4] = '{2'd2, 8'hFF, 11, 2, 16, 11, 110};
    vt[5] = '{2'd2, 8'h00, 11, 2, 16, 11, 110};

    for (int i = 0; i < 6; i++) begin
      clr_s();
      push_frame(0, vt[i].pat, vt[i].yl);
      s_if.pattern_sel = vt[i].pat;
      s_if.y_level     = vt[i].yl;
      pulse_start(0);
      repeat (4) @(negedge clk);
      // Frame has begun; the latched controls must not follow these.
      s_if.pattern_sel = ~vt[i].pat;
      s_if.y_level     = ~vt[i].yl;
      wait_done(0, 400, ok);
      repeat (4) @(negedge clk);
      chk("s_busy_after", s_if.busy, 0);
      chk("s_vsync_bytes", s_vs, vt[i].exp_vs);
      chk("s_href_pulses", s_hrise, vt[i].exp_rise);
      chk("s_href_bytes", s_hr, vt[i].exp_hr);
      chk("s_vback_bytes", s_bk, vt[i].exp_bk);
      chk("s_frame_clks", s_span, vt[i].exp_span);
      chk("s_done_count", s_done, 1);
      chk("s_sb_empty", s_q.size(), 0);
    end

    // Continuous: two frames back-to-back, continuous cleared mid-frame 2.
    clr_s();
    s_if.pattern_sel = 2'd2; s_if.y_level = 8'h3C; s_if.continuous = 1'b1;
    push_frame(0, 2'd2, 8'h3C);
    push_frame(0, 2'd2, 8'h3C);
    pulse_start(0);
    s_busy_low = 0;
    wait_done(0, 400, ok);
    n = 0;
    while (s_vsrise < 2 && n < 40) begin @(negedge clk); n++; end
    chk("s_cont_vsync_rises", s_vsrise, 2);
    chk("s_cont_gap_clks", s_gap, 2);
    repeat (40) @(negedge clk);
    s_if.continuous = 1'b0;
    wait_done(0, 400, ok);
    chk("s_cont_busy_low_clks", s_busy_low, 0);
    chk("s_cont_frame2_clks", s_span, 110);
    repeat (300) @(negedge clk);
    chk("s_cont_total_vsync", s_vsrise, 2);
    chk("s_cont_total_done", s_done, 2);
    chk("s_cont_busy_end", s_if.busy, 0);
    chk("s_cont_sb_empty", s_q.size(), 0);

    // start mid-frame and coincident with frame_done are both ignored.
    clr_s();
    s_if.pattern_sel = 2'd1; s_if.y_level = 8'h00;
    push_frame(0, 2'd1, 8'h00);
    pulse_start(0);
    repeat (40) @(negedge clk);
    s_if.start = 1'b1; @(negedge clk); s_if.start = 1'b0;
    wait_done(0, 400, ok);
    s_if.start = 1'b1; @(negedge clk); s_if.start = 1'b0;
    repeat (300) @(negedge clk);
    chk("s_ign_vsync_rises", s_vsrise, 1);
    chk("s_ign_done", s_done, 1);
    chk("s_ign_busy", s_if.busy, 0);
    chk("s_ign_sb_empty", s_q.size(), 0);

    // Reset during active line 1 aborts the frame.
    clr_s();
    s_if.pattern_sel = 2'd2; s_if.y_level = 8'h77;
    push_frame(0, 2'd2, 8'h77);
    pulse_start(0);
    n = 0;
    while (s_hrise < 2 && n < 400) begin @(negedge clk); n++; end
    chk("s_rst_reached_line1", s_hrise, 2);
    repeat (2) @(negedge clk);
    #2 rst_s = 1'b0;
    #1;
    chk("s_rst_vsync", s_if.vsync, 0);
    chk("s_rst_href", s_if.href, 0);
    chk("s_rst_d", s_if.d, 0);
    chk("s_rst_busy", s_if.busy, 0);
    chk("s_rst_pclk", s_if.pclk, 0);
    chk("s_rst_frame_done", s_if.frame_done, 0);
    repeat (3) @(negedge clk);
    chk("s_rst_no_done", s_done, 0);
    s_q.delete();
    s_tag = 8'h00;
    rst_s = 1'b1;
    clr_s();
    s_if.pattern_sel = 2'd2; s_if.y_level = 8'h5A;
    push_frame(0, 2'd2, 8'h5A);
    pulse_start(0);
    wait_done(0, 400, ok);
    repeat (4) @(negedge clk);
    chk("s_post_rst_frame_clks", s_span, 110);
    chk("s_post_rst_href_bytes", s_hr, 16);
    chk("s_post_rst_sb_empty", s_q.size(), 0);

`ifdef STREAM_FRAME_TAG_EN
    // Enough frames to wrap the 8-bit tag; pixel (0,0) carries the tag.
    s_if.pattern_sel = 2'd3; s_if.y_level = 8'h00;
    for (int f = 0; f < 257; f++) begin
      push_frame(0, 2'd3, 8'h00);
      pulse_start(0);
      wait_done(0, 400, ok);
      repeat (3) @(negedge clk);
    end
    chk("s_tag_sb_empty", s_q.size(), 0);
`endif
  endtask

  task automatic run_medium();
    logic [1:0] pats[3];
    bit ok;
    pats[0] = 2'd0; pats[1] = 2'd1; pats[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      m_done = 0;
      m_if.pattern_sel = pats[i];
      m_if.y_level = 8'(i * 37 + 5);
      push_frame(1, pats[i], m_if.y_level);
      pulse_start(1);
      wait_done(1, 20000, ok);
      repeat (4) @(negedge clk);
      chk("m_busy_after", m_if.busy, 0);
      chk("m_done_count", m_done, 1);
      chk("m_sb_empty", m_q.size(), 0);
    end
  endtask

  initial begin
    s_if.start = 0; s_if.continuous = 0; s_if.pattern_sel = 0; s_if.y_level = 0;
    m_if.start = 0; m_if.continuous = 0; m_if.pattern_sel = 0; m_if.y_level = 0;
    rst_s = 1'b1; rst_m = 1'b1;
    #2 rst_s = 1'b0; rst_m = 1'b0;
    #1;
    chk("reset_pclk", s_if.pclk, 0);
    chk("reset_vsync", s_if.vsync, 0);
    chk("reset_href", s_if.href, 0);
    chk("reset_d", s_if.d, 0);
    chk("reset_busy", s_if.busy, 0);
    chk("reset_frame_done", s_if.frame_done, 0);
    repeat (3) @(negedge clk);
    rst_s = 1'b1; rst_m = 1'b1;
    @(posedge clk); #1;
    chk("pclk_first_toggle", s_if.pclk, 1);
    @(posedge clk); #1;
    chk("pclk_second_toggle", s_if.pclk, 0);
    fork
      run_small();
      run_medium();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
